// File: rtl/st2cl_pkg.sv
// Shared head layout, default widths and head builder for the symbol-to-cache-line packer.
package st2cl_pkg;

    localparam int unsigned DEF_CL         = 512;
    localparam int unsigned DEF_CL_HEAD    = 16;
    localparam int unsigned DEF_CL_PAYLOAD = 496;
    localparam int unsigned DEF_ST2        = 8;

    localparam int unsigned LEN_W   = 10;
    localparam int unsigned SEQ_W   = 4;
    localparam int unsigned LEN_LSB = 0;
    localparam int unsigned SOP_BIT = 10;
    localparam int unsigned EOP_BIT = 11;
    localparam int unsigned SEQ_LSB = 12;

    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic             eop;
        logic             sop;
        logic [LEN_W-1:0] len;
    } cl_head_t;

    function automatic cl_head_t build_head(
        input logic [LEN_W-1:0] len,
        input logic             sop,
        input logic             eop,
        input logic [SEQ_W-1:0] seq
    );
        cl_head_t h;
        h.len = len;
        h.sop = sop;
        h.eop = eop;
        h.seq = seq;
        return h;
    endfunction

endpackage

// File: rtl/st2cl_pack_buf.sv
// Payload insert register and symbol count; exposes the line as it would look after this cycle's insert.
module st2cl_pack_buf #(
    parameter int unsigned       ST2        = 8,
    parameter int unsigned       CL_PAYLOAD = 496,
    parameter int unsigned       W_LEN      = 10,
    parameter logic [W_LEN-1:0]  MAX_SYM    = 10'd41
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ins,
    input  logic                  clr,
    input  logic [ST2-1:0]        din,
    output logic [W_LEN-1:0]      cnt,
    output logic [W_LEN-1:0]      len_c,
    output logic [CL_PAYLOAD-1:0] line_c,
    output logic                  full_c
);

    localparam int unsigned SLOTS = CL_PAYLOAD / ST2;

    logic [CL_PAYLOAD-1:0] payload;

    // Place the incoming symbol at slot cnt; unused slots stay zero.
    always_comb begin
        line_c = payload;
        for (int k = 0; k < int'(SLOTS); k++) begin
            if (ins && (cnt == W_LEN'(k))) begin
                line_c[k*ST2 +: ST2] = din;
            end
        end
    end

    assign len_c  = cnt + W_LEN'(ins);
    assign full_c = (len_c == MAX_SYM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            payload <= '0;
            cnt     <= '0;
        end else if (clr) begin
            payload <= '0;
            cnt     <= '0;
        end else if (ins) begin
            payload <= line_c;
            cnt     <= len_c;
        end
    end

endmodule

// File: rtl/st2cl_after_afu.sv
// Packs the framed AFU symbol stream into cache lines for the host-write FIFO.
// Define ST2CL_FRMSEQ_EN to carry a 4-bit frame sequence number in head bits 15:12.
module st2cl_after_afu
    import st2cl_pkg::*;
#(
    parameter int unsigned              CL              = DEF_CL,
    parameter int unsigned              CL_HEAD         = DEF_CL_HEAD,
    parameter int unsigned              CL_PAYLOAD      = DEF_CL_PAYLOAD,
    parameter int unsigned              ST2             = DEF_ST2,
    parameter int unsigned              w_len_CLHead    = LEN_W,
    parameter logic [w_len_CLHead-1:0]  MaxNumOfST_inCL = 10'd41
) (
    input  logic           clk,
    input  logic           rst,
    output logic           sink_ready,
    input  logic [ST2-1:0] sink_data,
    input  logic           sink_valid,
    input  logic           sink_sop,
    input  logic           sink_eop,
    input  logic           source_ready,
    output logic           ff_wrreq,
    output logic [CL-1:0]  ff_data,
    output logic           ff_wr_finish
);

    logic [w_len_CLHead-1:0] cnt;
    logic [w_len_CLHead-1:0] len_c;
    logic [CL_PAYLOAD-1:0]   line_c;
    logic                    full_c;
    logic                    split_c;
    logic                    accept_c;
    logic                    close_c;
    logic                    eop_c;
    logic                    sop_c;
    logic [SEQ_W-1:0]        seq_c;
    cl_head_t                head_c;

    logic out_valid;
    logic pending;
    logic line_sop;

    st2cl_pack_buf #(
        .ST2        (ST2),
        .CL_PAYLOAD (CL_PAYLOAD),
        .W_LEN      (w_len_CLHead),
        .MAX_SYM    (MaxNumOfST_inCL)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .ins    (accept_c),
        .clr    (close_c),
        .din    (sink_data),
        .cnt    (cnt),
        .len_c  (len_c),
        .line_c (line_c),
        .full_c (full_c)
    );

    // A sop landing on a partial line stalls one cycle while the old line closes without eop.
    assign split_c    = sink_valid & sink_sop & (cnt != '0);
    assign sink_ready = source_ready & ~pending & ~split_c;
    assign accept_c   = sink_valid & sink_ready;
    assign eop_c      = accept_c & sink_eop;
    assign close_c    = (accept_c & (sink_eop | full_c)) | (split_c & source_ready & ~pending);
    assign sop_c      = (cnt == '0) ? (accept_c & sink_sop) : line_sop;

`ifdef ST2CL_FRMSEQ_EN
    logic [SEQ_W-1:0] seq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq <= '0;
        end else if (eop_c) begin
            seq <= seq + SEQ_W'(1);
        end
    end

    assign seq_c = seq;
`else
    assign seq_c = '0;
`endif

    assign head_c = build_head(LEN_W'(len_c), sop_c, eop_c, seq_c);

    // A held line goes out on the first cycle the FIFO can take it.
    assign ff_wrreq     = out_valid & source_ready;
    assign ff_wr_finish = ff_wrreq & ff_data[CL_PAYLOAD + EOP_BIT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_data   <= '0;
            out_valid <= 1'b0;
            pending   <= 1'b0;
            line_sop  <= 1'b0;
        end else begin
            pending <= out_valid & ~source_ready;
            if (close_c) begin
                ff_data   <= {CL_HEAD'(head_c), line_c};
                out_valid <= 1'b1;
            end else if (source_ready) begin
                out_valid <= 1'b0;
            end
            if (close_c) begin
                line_sop <= 1'b0;
            end else if (accept_c && (cnt == '0)) begin
                line_sop <= sink_sop;
            end
        end
    end

endmodule

// File: tb/tb_st2cl_after_afu.sv
// Bench for st2cl_after_afu: directed steps plus random frames scored against a frame-chunking model.
`timescale 1ns/1ps
module tb_st2cl_after_afu;

    localparam int MAX_A = 41;
    localparam int MAX_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         a_ready, a_valid, a_sop, a_eop, a_sr, a_wrreq, a_finish;
    logic [7:0]   a_data;
    logic [511:0] a_ff_data;
    logic         b_ready, b_valid, b_sop, b_eop, b_sr, b_wrreq, b_finish;
    logic [7:0]   b_data;
    logic [511:0] b_ff_data;

    logic rand_sr;
    logic force_sr;
    logic rnd_a;
    logic rnd_b;
    bit   gaps;

    assign a_sr = rand_sr ? rnd_a : force_sr;
    assign b_sr = rand_sr ? rnd_b : 1'b1;

    st2cl_after_afu #(.MaxNumOfST_inCL(10'd41)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .sink_ready   (a_ready),
        .sink_data    (a_data),
        .sink_valid   (a_valid),
        .sink_sop     (a_sop),
        .sink_eop     (a_eop),
        .source_ready (a_sr),
        .ff_wrreq     (a_wrreq),
        .ff_data      (a_ff_data),
        .ff_wr_finish (a_finish)
    );

    st2cl_after_afu #(.MaxNumOfST_inCL(10'd1)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .sink_ready   (b_ready),
        .sink_data    (b_data),
        .sink_valid   (b_valid),
        .sink_sop     (b_sop),
        .sink_eop     (b_eop),
        .source_ready (b_sr),
        .ff_wrreq     (b_wrreq),
        .ff_data      (b_ff_data),
        .ff_wr_finish (b_finish)
    );

    int total = 0;
    int bad   = 0;

    logic [511:0]  q_a [$];
    logic [511:0]  q_b [$];
    byte unsigned  fb [$];
    logic [3:0]    seq_m [2];
    logic [511:0]  ea;
    logic [511:0]  eb;
    logic [511:0]  held;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: a frame splits into max-sized chunks; first chunk carries sop, last carries eop.
    task automatic model_frame(input int inst, input bit sop, input bit eop);
        int mx;
        int n;
        int len;
        bit fs;
        bit fe;
        logic [511:0] l;
        mx = (inst == 0) ? MAX_A : MAX_B;
        n  = fb.size();
        for (int s = 0; s < n; s += mx) begin
            len = (n - s < mx) ? (n - s) : mx;
            fs  = sop && (s == 0);
            fe  = eop && (s + len == n);
            l   = '0;
            for (int k = 0; k < len; k++) l[8*k +: 8] = fb[s+k];
            l[505:496] = 10'(len);
            l[506]     = fs;
            l[507]     = fe;
`ifdef ST2CL_FRMSEQ_EN
            l[511:508] = seq_m[inst];
            if (fe) seq_m[inst] = seq_m[inst] + 4'd1;
`endif
            if (inst == 0) q_a.push_back(l);
            else           q_b.push_back(l);
        end
    endtask

    task automatic set_valid(input int inst, input logic v);
        if (inst == 0) a_valid = v;
        else           b_valid = v;
    endtask

    task automatic send_sym(input int inst, input logic [7:0] d, input bit sop, input bit eop);
        bit acc;
        acc = 1'b0;
        if (inst == 0) begin a_valid = 1'b1; a_data = d; a_sop = sop; a_eop = eop; end
        else           begin b_valid = 1'b1; b_data = d; b_sop = sop; b_eop = eop; end
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            acc = (inst == 0) ? a_ready : b_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check1("accept_timeout", int'(acc), 1);
    endtask

    task automatic send_frame(input int inst, input int n, input bit sop, input bit eop, input bit count_data);
        fb.delete();
        for (int k = 0; k < n; k++) fb.push_back(count_data ? 8'(k + 1) : 8'($urandom));
        model_frame(inst, sop, eop);
        for (int k = 0; k < n; k++) begin
            send_sym(inst, fb[k], sop && (k == 0), eop && (k == n - 1));
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                set_valid(inst, 1'b0);
                @(posedge clk);
                #1;
            end
        end
        set_valid(inst, 1'b0);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (((q_a.size() != 0) || (q_b.size() != 0)) && (i < 2000)) begin
            @(posedge clk);
            i++;
        end
        #1;
        check1("drain_left", q_a.size() + q_b.size(), 0);
    endtask

    // Scoreboard: every write must match the oldest predicted line.
    always @(negedge clk) begin
        if (a_wrreq) begin
            if (q_a.size() == 0) begin
                check1("a_unexpected_write", 1, 0);
            end else begin
                ea = q_a.pop_front();
                check("a_line", a_ff_data, ea);
                check1("a_finish", int'(a_finish), int'(ea[507]));
            end
        end
        if (b_wrreq) begin
            if (q_b.size() == 0) begin
                check1("b_unexpected_write", 1, 0);
            end else begin
                eb = q_b.pop_front();
                check("b_line", b_ff_data, eb);
                check1("b_finish", int'(b_finish), int'(eb[507]));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        rnd_a = ($urandom_range(0, 3) != 0);
        rnd_b = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit prev_eop;
        bit sop;
        bit eop;
        rst = 1'b1;
        a_valid = 1'b0; a_data = '0; a_sop = 1'b0; a_eop = 1'b0;
        b_valid = 1'b0; b_data = '0; b_sop = 1'b0; b_eop = 1'b0;
        rand_sr = 1'b0; force_sr = 1'b1; gaps = 1'b0;
        seq_m[0] = '0; seq_m[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        check1("rst_wrreq", int'(a_wrreq), 0);
        check1("rst_finish", int'(a_finish), 0);
        check("rst_data", a_ff_data, '0);
        check1("rst_ready", int'(a_ready), 1);
        rst = 1'b0;

        // Two-symbol frame 1,2.
        send_frame(0, 2, 1'b1, 1'b1, 1'b1);
        drain();
        check("t1_bytes", 512'(a_ff_data[15:0]), 512'(16'h0201));
        check("t1_head", 512'(a_ff_data[511:496]), 512'(16'h0C02));

        // 100-symbol frame spans three lines.
        send_frame(0, 100, 1'b1, 1'b1, 1'b1);
        drain();

        // FIFO stalls for five cycles right after a close.
        send_frame(0, 2, 1'b1, 1'b1, 1'b0);
        force_sr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) held = a_ff_data;
            check1("stall_ready", int'(a_ready), 0);
            check1("stall_wrreq", int'(a_wrreq), 0);
        end
        @(posedge clk);
        #1;
        force_sr = 1'b1;
        @(negedge clk);
        check1("stall_release_wrreq", int'(a_wrreq), 1);
        check("stall_data_held", a_ff_data, held);
        drain();

        // Asynchronous reset mid-frame discards the partial line.
        for (int k = 0; k < 10; k++) send_sym(0, 8'(k + 50), k == 0, 1'b0);
        a_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check1("mid_rst_wrreq", int'(a_wrreq), 0);
        check1("mid_rst_finish", int'(a_finish), 0);
        check("mid_rst_data", a_ff_data, '0);
        seq_m[0] = '0;
        seq_m[1] = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_frame(0, 2, 1'b1, 1'b1, 1'b0);
        drain();
        check("post_rst_head", 512'(a_ff_data[511:496]), 512'(16'h0C02));

        // Seventeen single-line frames walk the sequence field through a wrap.
        for (int f = 0; f < 17; f++) send_frame(0, int'($urandom_range(1, 41)), 1'b1, 1'b1, 1'b0);
        drain();

        // Random frames with backpressure, idle gaps, missing eop and sop-less runs.
        rand_sr  = 1'b1;
        gaps     = 1'b1;
        prev_eop = 1'b1;
        for (int f = 0; f < 30; f++) begin
            sop = prev_eop ? ($urandom_range(0, 7) != 0) : 1'b1;
            eop = (f == 29) ? 1'b1 : ($urandom_range(0, 5) != 0);
            send_frame(0, int'($urandom_range(1, 130)), sop, eop, 1'b0);
            prev_eop = eop;
        end
        drain();

        // One symbol per line: back-to-back two-symbol frames, then random short frames.
        rand_sr = 1'b0;
        gaps    = 1'b0;
        for (int f = 0; f < 3; f++) send_frame(1, 2, 1'b1, 1'b1, 1'b0);
        drain();
        rand_sr = 1'b1;
        gaps    = 1'b1;
        for (int f = 0; f < 12; f++) send_frame(1, int'($urandom_range(1, 4)), 1'b1, 1'b1, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/st2cl_after_afu.md
Name: st2cl_after_afu

Overview:
- Packs the AFU output symbol stream (ST2-bit symbols, sop/eop framed) into CL-bit cache lines for the host-write FIFO.
- Each cache line = CL_HEAD-bit head (symbol count plus frame flags) + CL_PAYLOAD-bit payload.
- Sits between the AFU source port and the write side of the cache-line FIFO; backpressure comes from source_ready.

Parameters:
- CL, 512, cache-line width in bits
- CL_HEAD, 16, head width; head occupies ff_data[CL-1 -: CL_HEAD]
- CL_PAYLOAD, 496, payload width; payload occupies ff_data[CL_PAYLOAD-1:0]; CL_HEAD+CL_PAYLOAD must equal CL
- ST2, 8, symbol width
- MaxNumOfST_inCL, 10'd41, max symbols per cache line; legal range 1..CL_PAYLOAD/ST2 (62 at defaults)
- w_len_CLHead, 10, width of the length field in the head

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous reset, active-high
- sink_ready  out  1  symbol accept enable
- sink_data  in  ST2  symbol
- sink_valid  in  1  symbol valid
- sink_sop  in  1  first symbol of a frame
- sink_eop  in  1  last symbol of a frame
- source_ready  in  1  FIFO can take a write
- ff_wrreq  out  1  FIFO write strobe, one cycle per cache line
- ff_data  out  CL  cache line
- ff_wr_finish  out  1  pulses with the ff_wrreq of a frame's last cache line

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: ff_wrreq=0, ff_wr_finish=0, ff_data=0, internal count=0, pending=0. No cache line is emitted for a partially filled line when rst asserts mid-frame; that data is discarded.
- sink_ready = source_ready & ~pending (combinational).
- A symbol is accepted when sink_valid & sink_ready.
- Symbol k of a line (k = 0..cnt-1) is placed at ff_data[ST2*k +: ST2]. Unused payload bits are 0.
- Head layout:
  - [w_len_CLHead-1:0] = symbol count, 1..MaxNumOfST_inCL
  - bit 10 = sop flag: the line holds a frame's first symbol
  - bit 11 = eop flag: the line holds a frame's last symbol
  - bits 15:12 = 0
- Line close: the line closes on the accepting cycle when (a) the symbol carries sink_eop, or (b) the count reaches MaxNumOfST_inCL. If both occur, it is a single close with the eop flag set.
- Close with source_ready high at the close cycle t: ff_wrreq=1 at t+1 with the completed ff_data. The next symbol may be accepted at t+1 and starts a new line at count 0.
- Close with source_ready low at t+1: the line is held in the output register and pending=1. sink_ready=0 while pending. ff_wrreq fires on the first cycle source_ready=1, then pending clears.
- ff_wr_finish = ff_wrreq & eop flag of the written line.
- sop handling:
  - A symbol with sink_sop while a line is partially filled (missing eop) closes the old line first, with its eop flag 0.
  - The sop symbol then starts a new line. This close-then-start takes one extra cycle, during which sink_ready=0.
- Symbols arriving outside a frame (valid without a preceding sop) are packed normally; the sop flag stays 0.
- The count register is w_len_CLHead bits wide and never wraps, because it is bounded by MaxNumOfST_inCL.

Optional Feature:
- Macro ST2CL_FRMSEQ_EN.
- Defined: head bits 15:12 carry a 4-bit frame sequence number. It is 0 after reset, increments after each line written with the eop flag, and wraps 15->0. Every line of a frame carries the same number.
- Undefined: bits 15:12 are 0 and the counter is absent.

Decomposition:
- Shared package st2cl_pkg holds:
  - head field bit positions: LEN_LSB=0, SOP_BIT=10, EOP_BIT=11, SEQ_LSB=12
  - default widths CL, CL_HEAD, CL_PAYLOAD
  - a function building the head from len, sop, eop and seq
- One sub-module, st2cl_pack_buf: payload shift/insert register plus count, with clear and close outputs. Control (pending, head assembly, write strobe) stays in the top.

Test Plan:
- Default params, 2-symbol frame with data 1,2, source_ready=1 -> one ff_wrreq. ff_data[7:0]=1, [15:8]=2, len=2, sop=1, eop=1, ff_wr_finish=1, payload bits above 15 are 0.
- 100-symbol frame, data 1..100 -> three lines. Lens 41,41,18. Flags sop/eop: (1,0),(0,0),(0,1). Third line byte0=83. ff_wr_finish only on the third line.
- MaxNumOfST_inCL=1, back-to-back 2-symbol frames -> one line per symbol, len=1 each. Flags per frame: first line sop=1 eop=0, second line sop=0 eop=1.
- source_ready low for 5 cycles right after a close -> sink_ready=0 and ff_wrreq=0 throughout. A single ff_wrreq follows source_ready rising, with data unchanged.
- rst asserted asynchronously after 10 symbols of a frame -> outputs 0 immediately, no write. The next 2-symbol frame produces len=2, sop=1.
- With ST2CL_FRMSEQ_EN, 17 single-line frames -> head[15:12] runs 0..15, then 0.
